flp_mul_wbq: RTL and testbench
==============================

FLP_MUL_WBQ -- requirements
Module: flp_mul_wbq

Interface
REQ-001 EWIDTH, 8, exponent width of packed product.
REQ-002 SWIDTH, 23, significand width of packed product; FWIDTH = 1+EWIDTH+SWIDTH.
REQ-003 DEPTH, 4, queue entries; power of two, >= 2; AW = log2(DEPTH).
REQ-004 TWIDTH, 4, width of the tag carried with each product.
REQ-005 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-006 nrst  in  1  reset; asynchronous, active-low.
REQ-007 i_p  in  FWIDTH  packed product from the flp_mul stage.
REQ-008 i_tag  in  TWIDTH  destination tag accompanying i_p.
REQ-009 i_valid  in  1  i_p/i_tag valid.
REQ-010 o_ready  out  1  queue can accept an entry this cycle.
REQ-011 o_p  out  FWIDTH  head-entry product.
REQ-012 o_tag  out  TWIDTH  head-entry tag.
REQ-013 o_flags  out  3  head-entry class {nan, inf, zero}.
REQ-014 o_valid  out  1  head entry valid.
REQ-015 i_ready  in  1  consumer accepts head entry.
REQ-016 o_count  out  AW+1  number of occupied entries.
REQ-017 o_sticky  out  3  accumulated {nan, inf, zero} since last clear.
REQ-018 i_clr  in  1  synchronous clear of o_sticky.

Function
REQ-019 Push SHALL occur when i_valid & o_ready; pop SHALL occur when o_valid & i_ready.
REQ-020 o_ready SHALL equal (o_count != DEPTH); no same-cycle pass-through when full, even if a pop occurs.
REQ-021 o_valid SHALL equal (o_count != 0); an entry pushed at edge N SHALL be visible at the outputs after edge N (1-cycle latency).
REQ-022 Storage: circular buffer, AW-bit write and read pointers wrapping DEPTH-1 -> 0; occupancy count held separately.
REQ-023 Simultaneous push and pop with 0 < o_count < DEPTH SHALL leave o_count unchanged and advance both pointers.
REQ-024 Push with o_count == 0 and i_ready high: entry SHALL appear next cycle, not be consumed in the push cycle.
REQ-025 Classification SHALL be computed at push time from i_p and stored per entry: nan = (exp all ones) & (sig != 0); inf = (exp all ones) & (sig == 0); zero = (exp == 0), denormals counting as zero; at most one bit set.
REQ-026 o_p, o_tag, o_flags SHALL be driven from the head entry registers; when o_valid is 0 their values are don't-care but SHALL NOT be X after reset (storage reset to 0).
REQ-027 o_sticky SHALL OR in the class bits of every pushed entry in the push cycle.
REQ-028 i_clr SHALL zero o_sticky on the next edge; with a simultaneous push, o_sticky SHALL become the pushed entry's class bits (set wins over clear).
REQ-029 i_valid when o_ready is low SHALL be ignored without state change; the producer holds i_p/i_tag stable until accepted.
REQ-030 Pop when o_valid is low SHALL be ignored.

Reset
REQ-031 While nrst is low, asynchronously: pointers = 0, o_count = 0, o_valid = 0, o_ready = 1, o_sticky = 3'b000, all storage = 0 (so o_p = 0, o_tag = 0, o_flags = 0).
REQ-032 Reset asserted mid-operation SHALL discard all entries; no partial push/pop SHALL complete on the reset edge.
REQ-033 First push SHALL be accepted on the first rising edge after nrst deasserts.

Verification
REQ-034 Push i_p=0x3F800000, i_tag=1, i_ready=1 -> next cycle o_valid=1, o_p=0x3F800000, o_tag=1, o_flags=000, o_count=1; following cycle o_count=0.
REQ-035 i_ready=0, push tags 0..4 back-to-back -> o_count=4, o_ready=0 after 4th; tag 4 held; then i_ready=1 -> tags pop 0,1,2,3,4 in order across pointer wrap.
REQ-036 Push 0x7FC00000, 0xFF800000, 0x00000001 -> o_flags 100, 010, 001 respectively; o_sticky=111.
REQ-037 o_sticky=100, assert i_clr with push of 0x7F800000 -> o_sticky=010 next cycle; i_clr alone -> 000.
REQ-038 Queue full (4 entries), i_valid=1 and i_ready=1 same cycle -> pop only, o_count=3, new entry accepted next cycle.
REQ-039 With o_count=3, pull nrst low between edges -> immediately o_valid=0, o_count=0, o_ready=1, o_sticky=000; after release, push 0x40000000 -> o_p=0x40000000 next cycle.

Source files
------------

// File: rtl/flp_mul_wbq.sv
`default_nettype none
// ============================================================================
//  Module   : flp_mul_wbq
//  Purpose  : Write-back queue behind the floating-point multiplier. Buffers
//             packed products with their destination tags, classifies each
//             product (NaN / Inf / zero) as it is pushed, and accumulates a
//             sticky record of every class seen since the last clear.
//  Ports    : clk, nrst          clock, asynchronous active-low reset
//             i_p, i_tag,        producer side: product, tag, valid;
//             i_valid, o_ready   accepted when i_valid & o_ready
//             o_p, o_tag,        consumer side: head entry and its class
//             o_flags, o_valid,  {nan, inf, zero}; popped when
//             i_ready            o_valid & i_ready
//             o_count            occupied entries
//             o_sticky, i_clr    accumulated {nan, inf, zero}, clear
//  Revision : 1.0  initial release
// ============================================================================
module flp_mul_wbq #(
  parameter  int EWIDTH = 8,
  parameter  int SWIDTH = 23,
  parameter  int DEPTH  = 4,
  parameter  int TWIDTH = 4,
  localparam int FWIDTH = 1 + EWIDTH + SWIDTH,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [FWIDTH-1:0] i_p,
  input  logic [TWIDTH-1:0] i_tag,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [FWIDTH-1:0] o_p,
  output logic [TWIDTH-1:0] o_tag,
  output logic [2:0]        o_flags,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [AW:0]       o_count,
  output logic [2:0]        o_sticky,
  input  logic              i_clr
);

  localparam int          CW      = AW + 1;
  localparam logic [AW:0] c_depth = CW'(DEPTH);

  logic [FWIDTH-1:0] r_p_mem    [DEPTH];
  logic [TWIDTH-1:0] r_tag_mem  [DEPTH];
  logic [2:0]        r_flag_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [2:0]        r_sticky;

  logic              w_push;
  logic              w_pop;
  logic [EWIDTH-1:0] w_exp;
  logic              w_exp_ones;
  logic              w_exp_zero;
  logic              w_sig_nz;
  logic [2:0]        w_class;

  // Handshakes are derived only from registered occupancy, so a full queue
  // never accepts in the same cycle it pops (no combinational pass-through).
  assign o_ready = (r_count != c_depth);
  assign o_valid = (r_count != '0);
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;

  // Classification of the incoming product; denormals count as zero, so the
  // three classes are mutually exclusive.
  assign w_exp      = i_p[FWIDTH-2 -: EWIDTH];
  assign w_exp_ones = &w_exp;
  assign w_exp_zero = ~|w_exp;
  assign w_sig_nz   = |i_p[SWIDTH-1:0];
  assign w_class    = {w_exp_ones & w_sig_nz, w_exp_ones & ~w_sig_nz, w_exp_zero};

  // Entry storage is reset so the head outputs are defined even when empty.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_p_mem[i]    <= '0;
        r_tag_mem[i]  <= '0;
        r_flag_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_p_mem[r_wr_ptr]    <= i_p;
      r_tag_mem[r_wr_ptr]  <= i_tag;
      r_flag_mem[r_wr_ptr] <= w_class;
    end
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A push in the same cycle as a clear still records its class: the clear
  // drops history, the new entry's class is then ORed in.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sticky <= '0;
    end else if (w_push) begin
      r_sticky <= (i_clr ? 3'b000 : r_sticky) | w_class;
    end else if (i_clr) begin
      r_sticky <= 3'b000;
    end
  end

  assign o_p      = r_p_mem[r_rd_ptr];
  assign o_tag    = r_tag_mem[r_rd_ptr];
  assign o_flags  = r_flag_mem[r_rd_ptr];
  assign o_count  = r_count;
  assign o_sticky = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_flp_mul_wbq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flp_mul_wbq
//  Purpose  : Self-checking bench for flp_mul_wbq. A queue-of-entries model
//             with IEEE-style classification provides expected values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_flp_mul_wbq;

  localparam int DEPTH = 4;

  logic        clk;
  logic        nrst;
  logic [31:0] i_p;
  logic [3:0]  i_tag;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] o_p;
  logic [3:0]  o_tag;
  logic [2:0]  o_flags;
  logic        o_valid;
  logic        i_ready;
  logic [2:0]  o_count;
  logic [2:0]  o_sticky;
  logic        i_clr;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [31:0] p;
    logic [3:0]  tag;
    logic [2:0]  f;
  } ent_t;

  ent_t       mq[$];
  logic [2:0] m_sticky = 3'b000;

  flp_mul_wbq #(.EWIDTH(8), .SWIDTH(23), .DEPTH(DEPTH), .TWIDTH(4)) dut (
    .clk(clk), .nrst(nrst),
    .i_p(i_p), .i_tag(i_tag), .i_valid(i_valid), .o_ready(o_ready),
    .o_p(o_p), .o_tag(o_tag), .o_flags(o_flags), .o_valid(o_valid),
    .i_ready(i_ready), .o_count(o_count), .o_sticky(o_sticky), .i_clr(i_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference classification straight from the binary32 field definitions.
  function automatic logic [2:0] cls(input logic [31:0] p);
    int unsigned e, s;
    e = (p / 32'h0080_0000) % 256;
    s = p % 32'h0080_0000;
    if (e == 255) return (s != 0) ? 3'b100 : 3'b010;
    if (e == 0)   return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [31:0] rand_p();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return {r[31], 8'hFF, 23'h0};
      1:       return {r[31], 8'hFF, r[22:1], 1'b1};
      2:       return {r[31], 8'h00, r[22:0]};
      default: return r;
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, then
  // settle 1 time unit past the edge for sampling.
  task automatic step(input logic v, input logic [31:0] p, input logic [3:0] t,
                      input logic r, input logic c);
    bit   mpush, mpop;
    ent_t e;
    i_valid = v; i_p = p; i_tag = t; i_ready = r; i_clr = c;
    mpush = v && (mq.size() < DEPTH);
    mpop  = r && (mq.size() > 0);
    @(posedge clk);
    if (mpop) mq.delete(0);
    if (mpush) begin
      e.p = p; e.tag = t; e.f = cls(p);
      mq.push_back(e);
      m_sticky = (c ? 3'b000 : m_sticky) | cls(p);
    end else if (c) begin
      m_sticky = 3'b000;
    end
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; i_valid = 1'b0; i_p = '0; i_tag = '0; i_ready = 1'b0; i_clr = 1'b0;
    #12;
    vectors++;
    if ({o_valid, o_ready, o_count, o_sticky} !== {1'b0, 1'b1, 3'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_ctrl: got v=%b r=%b cnt=%0d st=%b, expected v=0 r=1 cnt=0 st=000",
               o_valid, o_ready, o_count, o_sticky);
    end
    vectors++;
    if ({o_p, o_tag, o_flags} !== 39'd0) begin
      errors++;
      $display("FAIL reset_data: got p=%h tag=%h fl=%b, expected all zero", o_p, o_tag, o_flags);
    end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_single();
    step(1, 32'h3F80_0000, 4'd1, 1, 0);
    vectors++;
    if ({o_valid, o_p, o_tag, o_flags, o_count} !== {1'b1, 32'h3F80_0000, 4'd1, 3'b000, 3'd1}) begin
      errors++;
      $display("FAIL single_push: got v=%b p=%h tag=%0d fl=%b cnt=%0d, expected v=1 p=3f800000 tag=1 fl=000 cnt=1",
               o_valid, o_p, o_tag, o_flags, o_count);
    end
    step(0, 32'h0, 4'd0, 1, 0);
    vectors++;
    if ({o_valid, o_count} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL single_pop: got v=%b cnt=%0d, expected v=0 cnt=0", o_valid, o_count);
    end
  endtask

  task automatic test_fill_wrap();
    int idx;
    for (int i = 0; i < 5; i++) begin
      step(1, 32'h4000_0000 + i, 4'(i), 0, 0);
      if (i == 3) begin
        vectors++;
        if ({o_count, o_ready} !== {3'd4, 1'b0}) begin
          errors++;
          $display("FAIL fill_full: got cnt=%0d rdy=%b, expected cnt=4 rdy=0", o_count, o_ready);
        end
      end
    end
    vectors++;
    if ({o_count, o_tag} !== {3'd4, 4'd0}) begin
      errors++;
      $display("FAIL fill_hold: got cnt=%0d head=%0d, expected cnt=4 head=0", o_count, o_tag);
    end
    // Producer keeps offering tag 4 until it is taken.
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      if (idx < 5) begin
        vectors++;
        if ({o_valid, o_tag} !== {1'b1, 4'(idx)}) begin
          errors++;
          $display("FAIL wrap_order: got v=%b tag=%0d, expected v=1 tag=%0d", o_valid, o_tag, idx);
        end
      end
      step(k < 2, 32'h4000_0004, 4'd4, 1, 0);
      if (idx < 5) idx++;
    end
    vectors++;
    if ({o_valid, o_count} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL wrap_empty: got v=%b cnt=%0d, expected v=0 cnt=0", o_valid, o_count);
    end
  endtask

  task automatic test_classes();
    logic [31:0] pats [3];
    logic [2:0]  exp_f [3];
    pats[0] = 32'h7FC0_0000; pats[1] = 32'hFF80_0000; pats[2] = 32'h0000_0001;
    exp_f[0] = 3'b100; exp_f[1] = 3'b010; exp_f[2] = 3'b001;
    step(0, 32'h0, 4'd0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, pats[i], 4'(i), 0, 0);
    vectors++;
    if (o_sticky !== 3'b111) begin
      errors++;
      $display("FAIL class_sticky: got %b, expected 111", o_sticky);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (o_flags !== exp_f[i]) begin
        errors++;
        $display("FAIL class_flags[%0d]: got %b, expected %b", i, o_flags, exp_f[i]);
      end
      step(0, 32'h0, 4'd0, 1, 0);
    end
  endtask

  task automatic test_sticky_clr();
    step(1, 32'h7FC0_0000, 4'd2, 1, 1);
    vectors++;
    if (o_sticky !== 3'b100) begin
      errors++;
      $display("FAIL sticky_set: got %b, expected 100", o_sticky);
    end
    step(1, 32'h7F80_0000, 4'd3, 1, 1);
    vectors++;
    if (o_sticky !== 3'b010) begin
      errors++;
      $display("FAIL sticky_clr_push: got %b, expected 010", o_sticky);
    end
    step(0, 32'h0, 4'd0, 1, 1);
    vectors++;
    if (o_sticky !== 3'b000) begin
      errors++;
      $display("FAIL sticky_clr: got %b, expected 000", o_sticky);
    end
    step(0, 32'h0, 4'd0, 1, 0);
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) step(1, 32'h1000_0000 + i, 4'(8 + i), 0, 0);
    step(1, 32'h1234_5678, 4'd12, 1, 0);
    vectors++;
    if ({o_count, o_ready, o_tag} !== {3'd3, 1'b1, 4'd9}) begin
      errors++;
      $display("FAIL full_pop_only: got cnt=%0d rdy=%b head=%0d, expected cnt=3 rdy=1 head=9",
               o_count, o_ready, o_tag);
    end
    step(1, 32'h1234_5678, 4'd12, 0, 0);
    vectors++;
    if (o_count !== 3'd4) begin
      errors++;
      $display("FAIL full_retry: got cnt=%0d, expected 4", o_count);
    end
    for (int i = 0; i < 4; i++) step(0, 32'h0, 4'd0, 1, 0);
    vectors++;
    if ({o_count, mq.size() == 0} !== {3'd0, 1'b1}) begin
      errors++;
      $display("FAIL full_drain: got cnt=%0d, expected 0", o_count);
    end
  endtask

  task automatic test_async_reset();
    step(1, 32'h7FC0_0001, 4'd5, 0, 0);
    step(1, 32'h3F00_0000, 4'd6, 0, 0);
    step(1, 32'hC000_0000, 4'd7, 0, 0);
    vectors++;
    if (o_count !== 3'd3) begin
      errors++;
      $display("FAIL arst_pre: got cnt=%0d, expected 3", o_count);
    end
    i_valid = 1'b1;
    #2 nrst = 1'b0;
    #1;
    vectors++;
    if ({o_valid, o_count, o_ready, o_sticky, o_p} !== {1'b0, 3'd0, 1'b1, 3'b000, 32'h0}) begin
      errors++;
      $display("FAIL arst_now: got v=%b cnt=%0d rdy=%b st=%b p=%h, expected v=0 cnt=0 rdy=1 st=000 p=0",
               o_valid, o_count, o_ready, o_sticky, o_p);
    end
    mq.delete();
    m_sticky = 3'b000;
    @(posedge clk); #1;
    vectors++;
    if (o_count !== 3'd0) begin
      errors++;
      $display("FAIL arst_hold: got cnt=%0d, expected 0", o_count);
    end
    i_valid = 1'b0;
    #3 nrst = 1'b1;
    step(1, 32'h4000_0000, 4'd1, 0, 0);
    vectors++;
    if ({o_valid, o_p} !== {1'b1, 32'h4000_0000}) begin
      errors++;
      $display("FAIL arst_first_push: got v=%b p=%h, expected v=1 p=40000000", o_valid, o_p);
    end
    step(0, 32'h0, 4'd0, 1, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, rand_p(), 4'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 7) == 0);
      vectors++;
      if ({o_count, o_valid, o_ready, o_sticky} !==
          {3'(mq.size()), mq.size() != 0, mq.size() != DEPTH, m_sticky}) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: got cnt=%0d v=%b r=%b st=%b, expected cnt=%0d st=%b",
                 n, o_count, o_valid, o_ready, o_sticky, mq.size(), m_sticky);
      end
      if (mq.size() != 0) begin
        vectors++;
        if ({o_p, o_tag, o_flags} !== {mq[0].p, mq[0].tag, mq[0].f}) begin
          errors++;
          $display("FAIL rand_head[%0d]: got p=%h tag=%h fl=%b, expected p=%h tag=%h fl=%b",
                   n, o_p, o_tag, o_flags, mq[0].p, mq[0].tag, mq[0].f);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_wrap();
    test_classes();
    test_sticky_clr();
    test_full_push_pop();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
